// File: rtl/mul_iter_32.sv
// Iterative 32x32->64 multiplier; radix-2 Booth when MUL_SIGNED_EN is defined, unsigned shift-and-add otherwise.
// Latency: done pulses 33 cycles after the accepted start; one add/shift per cycle through adder_32_bit.
// Backpressure: start is accepted only in IDLE/DONE and ignored while busy; product holds until the next start.

module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second-level lookahead across the four 4-bit groups.
  assign gc[0] = c_in;
  assign gc[1] = gg[0] | (gp[0] & c_in);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum   = p ^ c;
  assign c_out = gc[4];
endmodule

module adder_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic c_mid;

  cla_16 u_lo (.a(a[15:0]),  .b(b[15:0]),  .c_in(c_in),  .sum(sum[15:0]),  .c_out(c_mid));
  cla_16 u_hi (.a(a[31:16]), .b(b[31:16]), .c_in(c_mid), .sum(sum[31:16]), .c_out(c_out));
endmodule

module mul_iter_32 #(
  parameter int N_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] mcand, acc, mplier;
  logic [5:0]  cnt;
  logic [31:0] mop, sum, hi_word;
  logic        cin_op, c_out, do_op, shift_in;
`ifdef MUL_SIGNED_EN
  logic        q_m1;
`endif

  adder_32_bit u_add (.a(acc), .b(mop), .c_in(cin_op), .sum(sum), .c_out(c_out));

  always_comb begin
    mop      = mcand;
    cin_op   = 1'b0;
    do_op    = 1'b0;
    shift_in = 1'b0;
`ifdef MUL_SIGNED_EN
    do_op = mplier[0] ^ q_m1;
    if (mplier[0] && !q_m1) begin
      mop    = ~mcand;
      cin_op = 1'b1;
    end
    // True 33-bit sign so that mcand = 0x80000000 survives the subtract.
    shift_in = do_op ? (acc[31] ^ mop[31] ^ c_out) : acc[31];
`else
    do_op    = mplier[0];
    shift_in = do_op & c_out;
`endif
    hi_word = do_op ? sum : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
`ifdef MUL_SIGNED_EN
      q_m1    <= 1'b0;
`endif
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      if (state == DONE) product <= {acc, mplier};
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
`ifdef MUL_SIGNED_EN
            q_m1   <= 1'b0;
`endif
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= {shift_in, hi_word[31:1]};
          mplier <= {hi_word[0], mplier[31:1]};
`ifdef MUL_SIGNED_EN
          q_m1   <= mplier[0];
`endif
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(N_ITER - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_iter_32.sv
// Directed bench for mul_iter_32: expected products queued at start, compared when done pulses.
// Covers reset values, latency/busy width, ignored mid-run start, output hold and mid-run reset abort.

module tb_mul_iter_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  mul_iter_32 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
`ifdef MUL_SIGNED_EN
    xe = {{32{x[31]}}, x};
    ye = {{32{y[31]}}, y};
`else
    xe = {32'b0, x};
    ye = {32'b0, y};
`endif
    return xe * ye;
  endfunction

  // Issue one multiply, follow it to done and check timing, result and hold.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] expv, input bit poke);
    int busy_n, done_at;
    bit overlap;
    logic [63:0] want;
    busy_n = 0; done_at = -1; overlap = 0;
    @(negedge clk); a = x; b = y; start = 1'b1; sb.push_back(expv);
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      if (poke && k == 10) begin a = ~x; b = y + 32'd7; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (busy && done) overlap = 1'b1;
      if (done) done_at = k;
    end
    want = sb.pop_front();
    check("done_latency", 64'(done_at), 64'd33);
    check("busy_cycles", 64'(busy_n), 64'd32);
    check("busy_done_overlap", 64'(overlap), 64'd0);
    check("product", product, want);
    @(negedge clk);
    check("done_single_cycle", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("product_hold_idle", product, want);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] rx, ry;
    bit seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    rst = 1'b0;

    run_op(32'd3, 32'd5, 64'h000000000000000F, 1'b0);
`ifdef MUL_SIGNED_EN
    run_op(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFFFFFFFFD6, 1'b0);
    run_op(32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0);
`else
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
    run_op(32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);
`endif
    run_op(32'h12345678, 32'h9ABCDEF0, model(32'h12345678, 32'h9ABCDEF0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      rx = $urandom; ry = $urandom;
      run_op(rx, ry, model(rx, ry), 1'b0);
    end

    // Abort a run with reset partway through.
    @(negedge clk); a = 32'h00012345; b = 32'h00000777; start = 1'b1;
    sb.push_back(model(32'h00012345, 32'h00000777));
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op(32'd2, 32'd2, 64'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
